// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid-buffered pipeline register with flush and saturating stall counter
module pipe_skid_reg #(
    parameter int PC_W    = 32,
    parameter int CTRL_W  = 16,
    parameter int DATA_W  = 64,
    parameter int KEEP_PC = 1,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [STAT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   main_pc, skid_pc;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              in_xfer, out_xfer;
    logic              main_from_in, main_from_skid, skid_from_in;

    assign in_ready  = (state != FULL) && !flush;
    assign out_valid = state != EMPTY;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_pc    = main_pc;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state;

    // next state and steering of which entry loads from where
    always_comb begin
        state_nx       = state;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        case (state)
            EMPTY: begin
                main_from_in = in_xfer;
                state_nx     = in_xfer ? ONE : EMPTY;
            end
            ONE: begin
                main_from_in = in_xfer && out_xfer;
                skid_from_in = in_xfer && !out_xfer;
                state_nx     = (in_xfer && !out_xfer) ? FULL : (!in_xfer && out_xfer) ? EMPTY : ONE;
            end
            FULL: begin
                main_from_skid = out_xfer;
                state_nx       = out_xfer ? ONE : FULL;
            end
            default: state_nx = EMPTY;
        endcase
        if (flush) state_nx = EMPTY;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nx;
    end

    // MAIN entry; flush wipes it but may keep the redirect PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_pc   <= '0;
            main_ctrl <= '0;
            main_data <= '0;
        end else if (flush) begin
            main_pc   <= (KEEP_PC != 0) ? in_pc : '0;
            main_ctrl <= '0;
            main_data <= '0;
        end else if (main_from_in) begin
            main_pc   <= in_pc;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end else if (main_from_skid) begin
            main_pc   <= skid_pc;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
        end
    end

    // SKID entry absorbs the input accepted while MAIN is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_pc   <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (skid_from_in) begin
            skid_pc   <= in_pc;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

    // saturating count of cycles where the output is held back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                               stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PC_W, 32, program-counter field width
- CTRL_W, 16, control field width; zeroed in bubbles
- DATA_W, 64, operand/data field width
- KEEP_PC, 1, flush loads in_pc into the PC field when 1, or 0 when 0
- STAT_W, 16, stall-counter width
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous kill of all held entries and of this cycle's input
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage accepts an entry this cycle
- in_pc  in  PC_W  entry PC
- in_ctrl  in  CTRL_W  entry control bits
- in_data  in  DATA_W  entry operands
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream consumes the output entry this cycle
- out_pc  out  PC_W  output PC
- out_ctrl  out  CTRL_W  output control; 0 whenever out_valid=0
- out_data  out  DATA_W  output operands
- occupancy  out  2  held entries (0, 1 or 2)
- stall_cnt  out  STAT_W  saturating count of back-pressure cycles

Function
REQ-003 Storage SHALL be two entries: MAIN, which drives the outputs, and SKID, which absorbs one entry under back-pressure.
REQ-004 States SHALL be EMPTY (occupancy 0), ONE (MAIN valid) and FULL (MAIN and SKID valid).
REQ-005 in_ready SHALL equal (state != FULL) AND NOT flush, combinationally.
REQ-006 An input transfer SHALL occur when in_valid AND in_ready; an output transfer SHALL occur when out_valid AND out_ready.
REQ-007 EMPTY: on an input transfer, MAIN SHALL load the input and the state SHALL go to ONE; otherwise the state SHALL stay EMPTY.
REQ-008 ONE, input and output transfer: MAIN SHALL load the input and the state SHALL stay ONE.
REQ-009 ONE, input transfer only: SKID SHALL load the input and the state SHALL go to FULL.
REQ-010 ONE, output transfer only: the state SHALL go to EMPTY.
REQ-011 ONE, no transfer: MAIN SHALL hold.
REQ-012 FULL, output transfer: MAIN SHALL load SKID and the state SHALL go to ONE; otherwise both entries SHALL hold.
REQ-013 Input-to-output latency SHALL be exactly 1 cycle when the stage is EMPTY, or when it is ONE with out_ready=1.
REQ-014 Order SHALL be preserved, with no entry lost or duplicated.
REQ-015 flush SHALL have priority over all transfers; the next state SHALL be EMPTY.
REQ-016 On flush, the MAIN ctrl and data fields SHALL be cleared to 0.
REQ-017 On flush, the MAIN PC field SHALL be loaded with in_pc when KEEP_PC=1, or with 0 when KEEP_PC=0.
REQ-018 On flush, the input of that cycle SHALL be discarded.
REQ-019 out_valid SHALL equal MAIN valid.
REQ-020 out_ctrl SHALL be forced to 0 while out_valid=0; out_pc and out_data SHALL show MAIN contents unmasked.
REQ-021 occupancy SHALL be registered state: EMPTY=0, ONE=1, FULL=2.
REQ-022 stall_cnt SHALL increment by 1 on every cycle with out_valid=1 and out_ready=0, SHALL saturate at 2^STAT_W-1, and SHALL be unaffected by flush.
REQ-023 Simultaneous in_valid and flush SHALL produce no input transfer, since in_ready=0.
REQ-024 Changes on out_ready while in_ready=0 SHALL have no effect on SKID contents.

Reset
REQ-025 rst=0 SHALL immediately, independent of clk, set the state to EMPTY and clear MAIN, SKID and stall_cnt to 0.
REQ-026 While rst=0, the outputs SHALL be: out_valid=0, in_ready=1, out_pc/out_ctrl/out_data=0, occupancy=0, stall_cnt=0.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; the first input transfer after release SHALL appear at the output 1 cycle later.

Verification
REQ-028 Pass-through: out_ready=1, entries A(pc 0x3000), B(pc 0x3004) on consecutive cycles -> out_valid, with pc 0x3000 then 0x3004, each 1 cycle after input; occupancy stays 1.
REQ-029 Back-pressure: out_ready=0, offer A then B -> occupancy 1, then 2; in_ready=0; offered C is not accepted; stall_cnt increments each stalled cycle; then out_ready=1 -> A, B, C output in order.
REQ-030 Flush while FULL with in_pc=0x3010, KEEP_PC=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data=0, out_pc=0x3010; the input on the flush cycle is never output.
REQ-031 Flush with KEEP_PC=0 and in_valid=1 -> out_pc=0, in_ready=0 during the flush cycle, no transfer counted.
REQ-032 Saturation: STAT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds; flush leaves stall_cnt=15.
REQ-033 Async reset: drop rst to 0 mid-cycle while FULL -> out_valid=0 and occupancy=0 before the next clk edge; after release, entry D is output 1 cycle after acceptance.
